// File: rtl/uart_rx_deframer.sv
// UART receive deframer: 16x oversampled 8N1 / 8-parity-1 receiver with a
// small frame FIFO drained over a valid/ready interface. Each FIFO entry
// carries the received byte plus its frame and parity error flags.
module uart_rx_deframer #(
    parameter int FifoDepth  = 4,
    parameter int SyncStages = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        rx_i,
    input  logic [15:0] baud_div_i,
    input  logic        parity_en_i,
    input  logic        parity_odd_i,
    output logic [7:0]  data_o,
    output logic        frame_err_o,
    output logic        parity_err_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        overrun_o,
    output logic        busy_o
);

    localparam int AW = $clog2(FifoDepth);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t state, state_next;

    logic [SyncStages-1:0] sync_q;
    logic                  rxs;

    logic [15:0] div_q;
    logic [15:0] div_eff;
    logic        par_en_q;
    logic        par_odd_q;

    logic [15:0] pre_cnt;
    logic [3:0]  tick_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_q;
    logic        par_err_q;
    logic        armed_q;
    logic        tick;

    logic start_det;
    logic start_ok;
    logic data_sample;
    logic par_sample;
    logic push;
    logic push_frame_err;

    logic [9:0]  mem [FifoDepth];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        full;
    logic        empty;
    logic        pop;
    logic        do_write;

    // Line synchroniser; resets to all ones so the line looks idle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], rx_i};
        end
    end

    assign rxs     = sync_q[SyncStages-1];
    assign div_eff = (div_q == 16'd0) ? 16'd1 : div_q;
    assign tick    = (state != IDLE) && (pre_cnt == div_eff - 16'd1);

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start, data bits, optional parity, stop
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!rxs && armed_q) state_next = START;
            end
            START: begin
                if (tick && tick_cnt == 4'd7) state_next = rxs ? IDLE : DATA;
            end
            DATA: begin
                if (tick && tick_cnt == 4'd15 && bit_cnt == 3'd7)
                    state_next = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                if (tick && tick_cnt == 4'd15) state_next = STOP;
            end
            STOP: begin
                if (tick && tick_cnt == 4'd15) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Per-state strobes that drive the datapath and FIFO
    always_comb begin
        start_det      = (state == IDLE) && !rxs && armed_q;
        start_ok       = (state == START) && tick && (tick_cnt == 4'd7) && !rxs;
        data_sample    = (state == DATA) && tick && (tick_cnt == 4'd15);
        par_sample     = (state == PARITY) && tick && (tick_cnt == 4'd15);
        push           = (state == STOP) && tick && (tick_cnt == 4'd15);
        push_frame_err = ~rxs;
        busy_o         = (state != IDLE);
    end

    // Configuration is frozen at start detect so mid-frame changes are ignored
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div_q     <= 16'd0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
        end else if (start_det) begin
            div_q     <= baud_div_i;
            par_en_q  <= parity_en_i;
            par_odd_q <= parity_odd_i;
        end
    end

    // Prescaler and 16x tick counter; the tick counter is rebased at mid-start
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pre_cnt  <= 16'd0;
            tick_cnt <= 4'd0;
        end else if (start_det || state == IDLE) begin
            pre_cnt  <= 16'd0;
            tick_cnt <= 4'd0;
        end else begin
            pre_cnt <= tick ? 16'd0 : pre_cnt + 16'd1;
            if (start_ok) begin
                tick_cnt <= 4'd0;
            end else if (tick) begin
                tick_cnt <= tick_cnt + 4'd1;
            end
        end
    end

    // Data shift register (LSB first), bit counter and parity check
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bit_cnt   <= 3'd0;
            shift_q   <= 8'd0;
            par_err_q <= 1'b0;
        end else if (start_det) begin
            bit_cnt   <= 3'd0;
            par_err_q <= 1'b0;
        end else begin
            if (data_sample) begin
                shift_q <= {rxs, shift_q[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (par_sample) begin
                par_err_q <= (^shift_q) ^ rxs ^ par_odd_q;
            end
        end
    end

    // Break suppression: a frame error disarms start detection until the line is seen high
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            armed_q <= 1'b1;
        end else if (push && push_frame_err) begin
            armed_q <= 1'b0;
        end else if (state == IDLE && rxs) begin
            armed_q <= 1'b1;
        end
    end

    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign pop      = valid_o && ready_i;
    assign do_write = push && (!full || pop);

    // FIFO storage and pointers; a push into a full FIFO without a pop is dropped
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overrun_o <= 1'b0;
            for (int i = 0; i < FifoDepth; i++) begin
                mem[i] <= 10'd0;
            end
        end else begin
            overrun_o <= push && full && !pop;
            if (do_write) begin
                mem[wr_ptr[AW-1:0]] <= {push_frame_err, par_err_q, shift_q};
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Head entry is read straight from the storage flops so it holds while stalled
    always_comb begin
        valid_o      = !empty;
        frame_err_o  = mem[rd_ptr[AW-1:0]][9];
        parity_err_o = mem[rd_ptr[AW-1:0]][8];
        data_o       = mem[rd_ptr[AW-1:0]][7:0];
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed testbench for uart_rx_deframer: serial frames are driven on rx_i and
// the popped FIFO entries are collected by a monitor for checking.
module tb_uart_rx_deframer;

    logic        clk;
    logic        rst;
    logic        rx;
    logic [15:0] baud_div;
    logic        parity_en;
    logic        parity_odd;
    logic [7:0]  data;
    logic        frame_err;
    logic        parity_err;
    logic        valid;
    logic        ready;
    logic        overrun;
    logic        busy;

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } entry_t;

    entry_t q[$];
    entry_t mon_e;
    int     checks;
    int     passed;
    int     ovr_cnt;
    int     rise_cnt;
    bit     busy_seen;
    bit     prev_valid;
    bit     prev_busy;
    bit     rise_prev_busy;
    bit     rise_busy;

    uart_rx_deframer #(.FifoDepth(4), .SyncStages(2)) dut (
        .CLK          (clk),
        .RST          (rst),
        .rx_i         (rx),
        .baud_div_i   (baud_div),
        .parity_en_i  (parity_en),
        .parity_odd_i (parity_odd),
        .data_o       (data),
        .frame_err_o  (frame_err),
        .parity_err_o (parity_err),
        .valid_o      (valid),
        .ready_i      (ready),
        .overrun_o    (overrun),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: records popped entries, overrun pulses and valid rising edges
    always @(negedge clk) begin
        if (!rst) begin
            if (valid && ready) begin
                mon_e.d  = data;
                mon_e.fe = frame_err;
                mon_e.pe = parity_err;
                q.push_back(mon_e);
            end
            if (overrun) ovr_cnt++;
            if (busy) busy_seen = 1'b1;
            if (valid && !prev_valid) begin
                rise_cnt++;
                rise_prev_busy = prev_busy;
                rise_busy      = busy;
            end
        end
        prev_valid = valid;
        prev_busy  = busy;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        wait_cycles(n * 16 * int'(baud_div));
    endtask

    // Drives one full frame; the line is left at the stop-bit level afterwards
    task automatic send_frame(input logic [7:0] b, input bit with_par, input bit par_bit,
                              input bit stop_bit);
        int bc;
        bc = 16 * int'(baud_div);
        rx = 1'b0;
        wait_cycles(bc);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cycles(bc);
        end
        if (with_par) begin
            rx = par_bit;
            wait_cycles(bc);
        end
        rx = stop_bit;
        wait_cycles(bc);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_cycles(5);
        @(negedge clk);
        checks++; if (valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", valid); else passed++;
        checks++; if (data !== 8'h00) $display("[TB] FAIL reset_data: got %h expected 00", data); else passed++;
        checks++; if (frame_err !== 1'b0) $display("[TB] FAIL reset_fe: got %b expected 0", frame_err); else passed++;
        checks++; if (parity_err !== 1'b0) $display("[TB] FAIL reset_pe: got %b expected 0", parity_err); else passed++;
        checks++; if (overrun !== 1'b0) $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); else passed++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passed++;
        wait_cycles(1);
        rst = 1'b0;
        idle_bits(1);
    endtask

    task automatic test_basic();
        q.delete();
        rise_cnt = 0;
        ready = 1'b1;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        idle_bits(1);
        checks++; if (q.size() !== 1) $display("[TB] FAIL basic_count: got %0d expected 1", q.size()); else passed++;
        checks++; if (rise_cnt !== 1) $display("[TB] FAIL basic_valid_pulses: got %0d expected 1", rise_cnt); else passed++;
        if (q.size() > 0) begin
            checks++; if (q[0].d !== 8'hA5) $display("[TB] FAIL basic_data: got %h expected a5", q[0].d); else passed++;
            checks++; if (q[0].fe !== 1'b0 || q[0].pe !== 1'b0)
                $display("[TB] FAIL basic_flags: got fe=%b pe=%b expected 0 0", q[0].fe, q[0].pe); else passed++;
        end
        checks++; if (rise_prev_busy !== 1'b1 || rise_busy !== 1'b0)
            $display("[TB] FAIL basic_latency: busy before/at valid rise %b/%b expected 1/0", rise_prev_busy, rise_busy);
            else passed++;
    endtask

    task automatic test_glitch();
        q.delete();
        busy_seen = 1'b0;
        rx = 1'b0;
        wait_cycles(20);
        rx = 1'b1;
        wait_cycles(80);
        @(negedge clk);
        checks++; if (busy_seen !== 1'b1) $display("[TB] FAIL glitch_busy_seen: got %b expected 1", busy_seen); else passed++;
        checks++; if (q.size() !== 0) $display("[TB] FAIL glitch_no_entry: got %0d expected 0", q.size()); else passed++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL glitch_idle: got busy %b expected 0", busy); else passed++;
    endtask

    task automatic test_parity();
        logic exp_pe [4];
        exp_pe[0] = 1'b0; exp_pe[1] = 1'b1; exp_pe[2] = 1'b1; exp_pe[3] = 1'b0;
        q.delete();
        parity_en = 1'b1;
        parity_odd = 1'b0;
        send_frame(8'h03, 1'b1, 1'b0, 1'b1); idle_bits(1);
        send_frame(8'h03, 1'b1, 1'b1, 1'b1); idle_bits(1);
        parity_odd = 1'b1;
        send_frame(8'h03, 1'b1, 1'b0, 1'b1); idle_bits(1);
        send_frame(8'h03, 1'b1, 1'b1, 1'b1); idle_bits(1);
        parity_en = 1'b0;
        parity_odd = 1'b0;
        checks++; if (q.size() !== 4) $display("[TB] FAIL parity_count: got %0d expected 4", q.size()); else passed++;
        for (int i = 0; i < 4 && i < q.size(); i++) begin
            checks++; if (q[i].pe !== exp_pe[i] || q[i].d !== 8'h03 || q[i].fe !== 1'b0)
                $display("[TB] FAIL parity_entry%0d: got d=%h pe=%b fe=%b expected d=03 pe=%b fe=0",
                         i, q[i].d, q[i].pe, q[i].fe, exp_pe[i]);
                else passed++;
        end
    endtask

    task automatic test_framing();
        q.delete();
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        rx = 1'b0;
        wait_cycles(3 * 16 * int'(baud_div));
        checks++; if (q.size() !== 1) $display("[TB] FAIL frame_break_hold: got %0d entries expected 1", q.size()); else passed++;
        idle_bits(1);
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        idle_bits(1);
        checks++; if (q.size() !== 2) $display("[TB] FAIL frame_count: got %0d expected 2", q.size()); else passed++;
        if (q.size() >= 2) begin
            checks++; if (q[0].d !== 8'h5A || q[0].fe !== 1'b1)
                $display("[TB] FAIL frame_first: got d=%h fe=%b expected 5a 1", q[0].d, q[0].fe); else passed++;
            checks++; if (q[1].d !== 8'h11 || q[1].fe !== 1'b0)
                $display("[TB] FAIL frame_second: got d=%h fe=%b expected 11 0", q[1].d, q[1].fe); else passed++;
        end
    endtask

    task automatic test_overrun();
        q.delete();
        ovr_cnt = 0;
        ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            send_frame(8'(i), 1'b0, 1'b0, 1'b1);
            idle_bits(1);
        end
        checks++; if (ovr_cnt !== 0) $display("[TB] FAIL overrun_early: got %0d expected 0", ovr_cnt); else passed++;
        send_frame(8'h05, 1'b0, 1'b0, 1'b1);
        idle_bits(1);
        checks++; if (ovr_cnt !== 1) $display("[TB] FAIL overrun_pulse: got %0d expected 1", ovr_cnt); else passed++;
        @(negedge clk);
        checks++; if (valid !== 1'b1 || data !== 8'h01)
            $display("[TB] FAIL overrun_head: got valid=%b d=%h expected 1 01", valid, data); else passed++;
        wait_cycles(10);
        @(negedge clk);
        checks++; if (data !== 8'h01) $display("[TB] FAIL overrun_head_stable: got %h expected 01", data); else passed++;
        checks++; if (q.size() !== 0) $display("[TB] FAIL overrun_no_pop: got %0d expected 0", q.size()); else passed++;
        wait_cycles(1);
        ready = 1'b1;
        wait_cycles(10);
        @(negedge clk);
        checks++; if (q.size() !== 4) $display("[TB] FAIL overrun_drain_count: got %0d expected 4", q.size()); else passed++;
        for (int i = 0; i < 4 && i < q.size(); i++) begin
            checks++; if (q[i].d !== 8'(i + 1))
                $display("[TB] FAIL overrun_drain%0d: got %h expected %h", i, q[i].d, 8'(i + 1)); else passed++;
        end
        checks++; if (valid !== 1'b0) $display("[TB] FAIL overrun_empty: got valid %b expected 0", valid); else passed++;
    endtask

    task automatic test_reset_midframe();
        int bc;
        bc = 16 * int'(baud_div);
        q.delete();
        rx = 1'b0;
        wait_cycles(bc);
        rx = 1'b1;
        wait_cycles(3 * bc + bc / 2);
        @(negedge clk);
        checks++; if (busy !== 1'b1) $display("[TB] FAIL midreset_busy_before: got %b expected 1", busy); else passed++;
        wait_cycles(1);
        rst = 1'b1;
        wait_cycles(2);
        @(negedge clk);
        checks++; if ({valid, busy, overrun, frame_err, parity_err, data} !== 13'd0)
            $display("[TB] FAIL midreset_outputs: got v=%b b=%b o=%b fe=%b pe=%b d=%h expected all 0",
                     valid, busy, overrun, frame_err, parity_err, data);
            else passed++;
        wait_cycles(3);
        rst = 1'b0;
        idle_bits(2);
        @(negedge clk);
        checks++; if (valid !== 1'b0 || q.size() !== 0)
            $display("[TB] FAIL midreset_no_partial: got valid=%b entries=%0d expected 0 0", valid, q.size()); else passed++;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        idle_bits(1);
        checks++; if (q.size() !== 1) $display("[TB] FAIL midreset_count: got %0d expected 1", q.size()); else passed++;
        if (q.size() > 0) begin
            checks++; if (q[0].d !== 8'h3C) $display("[TB] FAIL midreset_data: got %h expected 3c", q[0].d); else passed++;
        end
    endtask

    initial begin
        checks     = 0;
        passed     = 0;
        ovr_cnt    = 0;
        rise_cnt   = 0;
        busy_seen  = 1'b0;
        prev_valid = 1'b0;
        prev_busy  = 1'b0;
        rst        = 1'b1;
        rx         = 1'b1;
        baud_div   = 16'd4;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        ready      = 1'b1;
        test_reset();
        test_basic();
        test_glitch();
        test_parity();
        test_framing();
        test_overrun();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Serial receive stage that consumes the `tx_o` line of `apb_uart`. It sits downstream of the UART in the simulation top and in loopback test harnesses.
- Recovers 8N1 or 8-parity-1 frames using 16x oversampling.
- Checks start, parity and stop bits.
- Buffers received bytes plus per-byte error flags in a small FIFO, drained through a valid/ready interface.

Parameters:
- FifoDepth, 4, number of buffered frames; power of two, minimum 2.
- SyncStages, 2, flops in the `rx_i` synchroniser; minimum 2.

Ports:
- CLK  input  1  system clock.
- RST  input  1  reset; asynchronous, active-high.
- rx_i  input  1  serial line; idle high.
- baud_div_i  input  16  CLK cycles per oversample tick; bit time = 16*baud_div_i cycles.
- parity_en_i  input  1  1 = a parity bit follows the data bits.
- parity_odd_i  input  1  1 = odd parity, 0 = even parity.
- data_o  output  8  byte at the FIFO head.
- frame_err_o  output  1  stop bit of the head entry sampled 0.
- parity_err_o  output  1  parity mismatch on the head entry.
- valid_o  output  1  FIFO not empty.
- ready_i  input  1  consumer accepts the head entry.
- overrun_o  output  1  one-cycle pulse when a completed frame is dropped because the FIFO is full.
- busy_o  output  1  receive FSM not in IDLE.

Behaviour:

Reset values:
- RST asserted, any time including mid-frame: FSM to IDLE; FIFO emptied; prescaler, tick and bit counters cleared.
- Synchroniser flops set to 1 (line idle).
- All outputs 0.

Input handling:
- `rx_i` passes through the SyncStages flop chain.
- All logic uses the synchronised value `rxs`.

Baud sampling:
- `baud_div_i` is latched on start-bit detection. A latched value of 0 is treated as 1.
- The prescaler counts 0..div-1 and emits a tick when count == div-1.
- A tick counter runs 0..15 per bit.

FSM states:
- IDLE: when `rxs` is 0, clear the prescaler and tick counter and go to START.
- START: at tick 7 (mid-bit), if `rxs` is 1 the start bit was a glitch; return to IDLE with no push. Otherwise clear the tick counter and go to DATA.
- DATA: sample `rxs` at tick 15 of each bit, shifting LSB first. After the 8th sample go to PARITY if `parity_en_i` is 1, else to STOP.
- PARITY: sample at tick 15. parity_err = XOR(data bits, parity bit) XOR parity_odd. Expected result is 0 for even parity; a nonzero result is an error.
- STOP: sample at tick 15. frame_err = ~`rxs`. In the same cycle push {frame_err, parity_err, byte} and go to IDLE.
  - parity_err is 0 when parity is disabled.
  - The sample lands at the stop-bit middle, so back-to-back frames are not missed.

Framing rules:
- `parity_en_i` and `parity_odd_i` are latched with `baud_div_i` at start detect.
- A frame with frame_err = 1 is still pushed.
- After a frame error, a line that stays low does not retrigger until `rxs` has been seen high in IDLE for at least one cycle (break suppression).

FIFO:
- `valid_o` rises the cycle after the push.
- `data_o` and both error flags are registered head-entry outputs, stable while `valid_o`=1 and `ready_i`=0.
- A pop occurs when `valid_o` and `ready_i` are both 1.
- Push while full with no pop in the same cycle: frame dropped, `overrun_o`=1 for one cycle, FIFO contents unchanged.
- Push and pop in the same cycle while full: both happen, no overrun.
- Push and pop in the same cycle while empty: the push is stored; `valid_o` rises next cycle.
- Read and write pointers are log2(FifoDepth)+1 bits wide and wrap naturally; full and empty are derived from the pointer MSB and the remaining bits.

`busy_o`: 1 whenever the state is not IDLE.

Test Plan:
1. Basic byte: baud_div=4 (64 cycles/bit), no parity, send 0xA5, `ready_i`=1.
   - Required: one `valid_o` pulse, `data_o`=0xA5, both error flags 0.
   - `valid_o` occurs 1 cycle after the stop-bit mid-sample.
2. Start glitch: drive `rx_i` low for 20 cycles, then high.
   - Required: `busy_o` pulses, no `valid_o`, FSM back in IDLE.
3. Parity: even parity, send 0x03 with parity bit 0, then 0x03 with parity bit 1.
   - Required: first entry parity_err=0, second entry parity_err=1.
   - Repeat with odd parity: results inverted.
4. Framing error: send 0x5A with stop bit driven 0, then line high, then 0x11.
   - Required: 0x5A with frame_err=1, then 0x11 with frame_err=0; no spurious frame while the line is held low.
5. Overrun: FifoDepth=4, `ready_i`=0, send 0x01..0x05.
   - Required: `overrun_o` pulses once, on the 5th frame.
   - Then `ready_i`=1 drains 0x01,0x02,0x03,0x04 in order; `valid_o` drops after the 4th.
6. Reset mid-frame: assert RST during DATA bit 3 of 0xFF, release, send 0x3C.
   - Required: outputs 0 during reset, no partial byte, then exactly one entry 0x3C.
